// File: rtl/logic_gate_unit.sv
// Registered 8-op bitwise/reduce gate with a 2-entry valid/ready output buffer; result on y one edge after accept.
// in_ready drops only when both entries are full; optional op_count under LOGIC_GATE_UNIT_STATS_EN.
module logic_gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef LOGIC_GATE_UNIT_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_res;
  logic             w_acc;
  logic             w_drain;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_to_out;

  always_comb begin
    w_res = '0;
    case (op)
      3'b000: w_res = a & b;
      3'b001: w_res = ~(a & b);
      3'b010: w_res = a | b;
      3'b011: w_res = ~(a | b);
      3'b100: w_res = a ^ b;
      3'b101: w_res = ~(a ^ b);
      3'b110: w_res = ~a;
      default: w_res[0] = ~&a;
    endcase
  end

  // in_ready depends only on registered occupancy (and rst), never on out_ready
  assign in_ready  = !rst && (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign y         = r_out;
  assign w_acc     = in_valid && in_ready;
  assign w_drain   = out_valid && out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = S_ONE;
          w_load_out  = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_drain) begin
          w_load_out = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_state_nxt   = S_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out) begin
        r_out <= w_res;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_res;
      end
    end
  end

`ifdef LOGIC_GATE_UNIT_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_drain && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule
